// File: rtl/lsu_pipe.sv
// Three-stage load/store unit (IDLE -> MEM -> RSP) for a byte-addressed dmem, output registers and a switch port.
// Define LSU_MISALIGN_TRAP_EN to report misaligned word/half accesses as errors instead of masking the low address bits.
module lsu_pipe #(
   parameter int DMEM_AW = 14,
   parameter int IO_REGS = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_req_valid,
   output logic                   o_req_ready,
   input  logic [31:0]            i_req_addr,
   input  logic                   i_req_wren,
   input  logic [1:0]             i_req_op,
   input  logic                   i_req_un,
   input  logic [31:0]            i_req_data,
   output logic                   o_rsp_valid,
   input  logic                   i_rsp_ready,
   output logic [31:0]            o_rsp_data,
   output logic                   o_rsp_err,
   input  logic [31:0]            i_io_sw,
   output logic [32*IO_REGS-1:0]  o_io_out
);

   localparam logic [4:0] IO_REGS_W = 5'(IO_REGS);

   typedef enum logic [1:0] {
      IDLE,
      MEM,
      RSP
   } state_e;

   state_e state_q, state_d;

   logic [31:0] reqAddr_q;
   logic        reqWren_q;
   logic [1:0]  reqOp_q;
   logic        reqUn_q;
   logic [31:0] reqData_q;

   logic [31:0] rspData_q;
   logic        rspErr_q;

   logic [31:0] outReg_q [IO_REGS];
   logic [31:0] dmem [2**DMEM_AW];

   logic               isDmem, isOut, isSw, mapped, misalign, accessOk;
   logic [1:0]         laneOff;
   logic [3:0]         byteEn;
   logic [31:0]        wrData, rawRead, shifted, loadVal;
   logic               doWrite, memWe, outWe;
   logic [DMEM_AW-1:0] memIdx;

   // Next-state logic; the handshakes only exist in IDLE and RSP, so there is never any overlap.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (i_req_valid) state_d = MEM;
         MEM:     state_d = RSP;
         RSP:     if (i_rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign o_req_ready = (state_q == IDLE);
   assign o_rsp_valid = (state_q == RSP);
   assign o_rsp_data  = rspData_q;
   assign o_rsp_err   = rspErr_q;

   // Region decode of the captured address; the switch port is read-only.
   always_comb begin
      isDmem = (reqAddr_q[31:16] == 16'h0000);
      isOut  = (reqAddr_q[31:16] == 16'h1000) && ({1'b0, reqAddr_q[15:12]} < IO_REGS_W);
      isSw   = (reqAddr_q[31:16] == 16'h1001);
      mapped = reqWren_q ? (isDmem || isOut) : (isDmem || isOut || isSw);
`ifdef LSU_MISALIGN_TRAP_EN
      misalign = (!reqOp_q[1] && (reqAddr_q[1:0] != 2'b00)) ||
                 ((reqOp_q == 2'b10) && reqAddr_q[0]);
`else
      misalign = 1'b0;
`endif
      accessOk = mapped && !misalign;
   end

   // Lane offset is masked to the access size, so untrapped misaligned accesses fall onto the aligned lanes.
   always_comb begin
      laneOff = 2'b00;
      byteEn  = 4'b1111;
      wrData  = reqData_q;
      if (reqOp_q == 2'b10) begin
         laneOff = {reqAddr_q[1], 1'b0};
         byteEn  = reqAddr_q[1] ? 4'b1100 : 4'b0011;
         wrData  = {2{reqData_q[15:0]}};
      end else if (reqOp_q == 2'b11) begin
         laneOff = reqAddr_q[1:0];
         byteEn  = 4'b0001 << reqAddr_q[1:0];
         wrData  = {4{reqData_q[7:0]}};
      end
   end

   assign memIdx = reqAddr_q[DMEM_AW+1:2];

   always_comb begin
      rawRead = 32'h0;
      if (isDmem) begin
         rawRead = dmem[memIdx];
      end else if (isSw) begin
         rawRead = i_io_sw;
      end else begin
         for (int k = 0; k < IO_REGS; k++) begin
            if (isOut && (reqAddr_q[15:12] == 4'(k))) rawRead = outReg_q[k];
         end
      end
   end

   always_comb begin
      shifted = rawRead >> {laneOff, 3'b000};
      loadVal = shifted;
      if (reqOp_q == 2'b10) begin
         loadVal = reqUn_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      end else if (reqOp_q == 2'b11) begin
         loadVal = reqUn_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      end
   end

   // A reset arriving in MEM wins over the write, so the aborted store leaves no trace.
   assign doWrite = (state_q == MEM) && reqWren_q && accessOk && !i_reset;
   assign memWe   = doWrite && isDmem;
   assign outWe   = doWrite && isOut;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= IDLE;
         rspData_q <= 32'h0;
         rspErr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == MEM) begin
            rspData_q <= (reqWren_q || !accessOk) ? 32'h0 : loadVal;
            rspErr_q  <= !accessOk;
         end
      end
   end

   // Request capture needs no reset: it is only consumed after a fresh accept.
   always_ff @(posedge i_clk) begin
      if ((state_q == IDLE) && i_req_valid && !i_reset) begin
         reqAddr_q <= i_req_addr;
         reqWren_q <= i_req_wren;
         reqOp_q   <= i_req_op;
         reqUn_q   <= i_req_un;
         reqData_q <= i_req_data;
      end
   end

   always_ff @(posedge i_clk) begin
      for (int k = 0; k < IO_REGS; k++) begin
         if (i_reset) begin
            outReg_q[k] <= 32'h0;
         end else if (outWe && (reqAddr_q[15:12] == 4'(k))) begin
            for (int b = 0; b < 4; b++) begin
               if (byteEn[b]) outReg_q[k][8*b +: 8] <= wrData[8*b +: 8];
            end
         end
      end
   end

   // Data memory keeps its contents across reset.
   always_ff @(posedge i_clk) begin
      if (memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (byteEn[b]) dmem[memIdx][8*b +: 8] <= wrData[8*b +: 8];
         end
      end
   end

   for (genvar g = 0; g < IO_REGS; g++) begin : gOut
      assign o_io_out[32*g +: 32] = outReg_q[g];
   end

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed self-checking bench for lsu_pipe with hand-computed expected values.
// Honours LSU_MISALIGN_TRAP_EN so the same bench checks both builds.
module tb_lsu_pipe;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic         i_req_valid;
   logic         o_req_ready;
   logic [31:0]  i_req_addr;
   logic         i_req_wren;
   logic [1:0]   i_req_op;
   logic         i_req_un;
   logic [31:0]  i_req_data;
   logic         o_rsp_valid;
   logic         i_rsp_ready;
   logic [31:0]  o_rsp_data;
   logic         o_rsp_err;
   logic [31:0]  i_io_sw;
   logic [255:0] o_io_out;

   int compared = 0;
   int mismatched = 0;

   localparam logic [1:0] OP_W = 2'b00, OP_H = 2'b10, OP_B = 2'b11;

   lsu_pipe #(.DMEM_AW(14), .IO_REGS(8)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_addr(i_req_addr), .i_req_wren(i_req_wren), .i_req_op(i_req_op),
      .i_req_un(i_req_un), .i_req_data(i_req_data),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
      .i_io_sw(i_io_sw), .o_io_out(o_io_out)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One full transaction with i_rsp_ready high; lat counts clock edges from accept to the first valid response.
   task automatic applyStimulus(input logic [31:0] addr, input logic wren, input logic [1:0] op,
                                input logic un, input logic [31:0] data,
                                output logic [31:0] rdata, output logic err, output int lat);
      @(negedge i_clk);
      i_req_valid = 1'b1;
      i_req_addr  = addr;
      i_req_wren  = wren;
      i_req_op    = op;
      i_req_un    = un;
      i_req_data  = data;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      lat = 0;
      while (!o_rsp_valid && lat < 10) begin
         @(posedge i_clk);
         #1;
         lat++;
      end
      if (!o_rsp_valid) checkOutput("rsp_timeout", 256'(0), 256'(1));
      rdata = o_rsp_data;
      err   = o_rsp_err;
      @(posedge i_clk);
      #1;
   endtask

   task automatic doTxn(input string tag, input logic [31:0] addr, input logic wren, input logic [1:0] op,
                        input logic un, input logic [31:0] data, input logic [31:0] expData, input logic expErr);
      logic [31:0] rdata;
      logic        err;
      int          lat;
      applyStimulus(addr, wren, op, un, data, rdata, err, lat);
      checkOutput({tag, "_data"}, 256'(rdata), 256'(expData));
      checkOutput({tag, "_err"}, 256'(err), 256'(expErr));
      checkOutput({tag, "_lat"}, 256'(lat), 256'(1));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [255:0] ioExp;
      i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_req_wren = 1'b0;
      i_req_op = OP_W; i_req_un = 1'b0; i_req_data = '0; i_rsp_ready = 1'b1; i_io_sw = '0;
      repeat (3) @(posedge i_clk);
      #1;
      checkOutput("rst_req_ready", 256'(o_req_ready), 256'(1));
      checkOutput("rst_rsp_valid", 256'(o_rsp_valid), 256'(0));
      checkOutput("rst_rsp_data", 256'(o_rsp_data), 256'(0));
      checkOutput("rst_rsp_err", 256'(o_rsp_err), 256'(0));
      checkOutput("rst_io_out", o_io_out, 256'(0));
      @(negedge i_clk);
      i_reset = 1'b0;

      // Byte/half/word lane extraction in dmem
      doTxn("st_w_10", 32'h0000_0010, 1'b1, OP_W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
      doTxn("ld_bu_13", 32'h0000_0013, 1'b0, OP_B, 1'b1, 32'h0, 32'h0000_00DE, 1'b0);
      doTxn("ld_hs_12", 32'h0000_0012, 1'b0, OP_H, 1'b0, 32'h0, 32'hFFFF_DEAD, 1'b0);
      doTxn("ld_hu_12", 32'h0000_0012, 1'b0, OP_H, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0);
      doTxn("ld_bs_10", 32'h0000_0010, 1'b0, OP_B, 1'b0, 32'h0, 32'hFFFF_FFEF, 1'b0);
      doTxn("ld_bs_11", 32'h0000_0011, 1'b0, OP_B, 1'b0, 32'h0, 32'hFFFF_FFBE, 1'b0);
      doTxn("st_b_11", 32'h0000_0011, 1'b1, OP_B, 1'b0, 32'h0000_0042, 32'h0, 1'b0);
      doTxn("st_h_12", 32'h0000_0012, 1'b1, OP_H, 1'b0, 32'hFFFF_1234, 32'h0, 1'b0);
      doTxn("ld_w_10", 32'h0000_0010, 1'b0, OP_W, 1'b0, 32'h0, 32'h1234_42EF, 1'b0);
      doTxn("st_w_10b", 32'h0000_0010, 1'b1, OP_W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);

      // Output registers
      doTxn("st_b_out2", 32'h1000_2001, 1'b1, OP_B, 1'b0, 32'hFFFF_FF5A, 32'h0, 1'b0);
      ioExp = '0;
      ioExp[95:64] = 32'h0000_5A00;
      checkOutput("io_out_b", o_io_out, ioExp);
      doTxn("st_h_out2", 32'h1000_2002, 1'b1, OP_H, 1'b0, 32'h0000_ABCD, 32'h0, 1'b0);
      ioExp[95:64] = 32'hABCD_5A00;
      checkOutput("io_out_h", o_io_out, ioExp);
      doTxn("ld_w_out2", 32'h1000_2000, 1'b0, OP_W, 1'b0, 32'h0, 32'hABCD_5A00, 1'b0);
      doTxn("st_w_out7", 32'h1000_7000, 1'b1, OP_W, 1'b0, 32'h8765_4321, 32'h0, 1'b0);
      ioExp[255:224] = 32'h8765_4321;
      checkOutput("io_out_w7", o_io_out, ioExp);

      // Unmapped accesses change nothing
      doTxn("st_out9", 32'h1000_9000, 1'b1, OP_W, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      doTxn("ld_out9", 32'h1000_9000, 1'b0, OP_W, 1'b0, 32'h0, 32'h0, 1'b1);
      doTxn("st_sw", 32'h1001_0000, 1'b1, OP_W, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b1);
      doTxn("ld_2000", 32'h2000_0000, 1'b0, OP_W, 1'b0, 32'h0, 32'h0, 1'b1);
      checkOutput("io_out_unmapped", o_io_out, ioExp);

      // Switch load held in RSP; the switch is sampled in MEM, not at accept
      @(negedge i_clk);
      i_rsp_ready = 1'b0;
      i_io_sw = 32'hFFFF_FFFF;
      i_req_valid = 1'b1; i_req_addr = 32'h1001_0000; i_req_wren = 1'b0; i_req_op = OP_W; i_req_un = 1'b0;
      @(posedge i_clk);
      #1;
      i_req_valid = 1'b0;
      i_io_sw = 32'h1234_5678;
      @(posedge i_clk);
      #1;
      i_io_sw = 32'h0;
      for (int c = 0; c < 5; c++) begin
         checkOutput("hold_valid", 256'(o_rsp_valid), 256'(1));
         checkOutput("hold_data", 256'(o_rsp_data), 256'(32'h1234_5678));
         checkOutput("hold_req_ready", 256'(o_req_ready), 256'(0));
         @(posedge i_clk);
         #1;
      end
      i_rsp_ready = 1'b1;
      @(posedge i_clk);
      #1;
      checkOutput("hold_release_valid", 256'(o_rsp_valid), 256'(0));
      checkOutput("hold_release_ready", 256'(o_req_ready), 256'(1));

      // Reset during MEM aborts a load and a store; dmem survives, output regs clear
      doTxn("st_w_40", 32'h0000_0040, 1'b1, OP_W, 1'b0, 32'h2222_2222, 32'h0, 1'b0);
      for (int t = 0; t < 2; t++) begin
         @(negedge i_clk);
         i_req_valid = 1'b1; i_req_addr = (t == 0) ? 32'h0000_0010 : 32'h0000_0040;
         i_req_wren = (t == 1); i_req_op = OP_W; i_req_data = 32'h1111_1111;
         @(posedge i_clk);
         #1;
         i_req_valid = 1'b0;
         @(negedge i_clk);
         i_reset = 1'b1;
         @(posedge i_clk);
         #1;
         checkOutput("abort_rsp_valid", 256'(o_rsp_valid), 256'(0));
         checkOutput("abort_req_ready", 256'(o_req_ready), 256'(1));
         checkOutput("abort_rsp_data", 256'(o_rsp_data), 256'(0));
         @(negedge i_clk);
         i_reset = 1'b0;
         @(posedge i_clk);
         #1;
         checkOutput("abort_no_rsp", 256'(o_rsp_valid), 256'(0));
      end
      checkOutput("rst_io_cleared", o_io_out, 256'(0));
      doTxn("ld_w_40", 32'h0000_0040, 1'b0, OP_W, 1'b0, 32'h0, 32'h2222_2222, 1'b0);
      doTxn("ld_w_10_kept", 32'h0000_0010, 1'b0, OP_W, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // Misaligned accesses
      doTxn("st_w_20", 32'h0000_0020, 1'b1, OP_W, 1'b0, 32'h0102_0304, 32'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      doTxn("st_w_21", 32'h0000_0021, 1'b1, OP_W, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b1);
      doTxn("ld_w_20", 32'h0000_0020, 1'b0, OP_W, 1'b0, 32'h0, 32'h0102_0304, 1'b0);
      doTxn("ld_hu_13", 32'h0000_0013, 1'b0, OP_H, 1'b1, 32'h0, 32'h0, 1'b1);
`else
      doTxn("st_w_21", 32'h0000_0021, 1'b1, OP_W, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
      doTxn("ld_w_20", 32'h0000_0020, 1'b0, OP_W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
      doTxn("ld_hu_13", 32'h0000_0013, 1'b0, OP_H, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
